jt12_pdm2pcm: RTL and testbench

Decoder for the 1-bit sigma-delta stream produced by `jt12_dac`. A second-order CIC decimator converts the bit stream back into signed PCM words at 1/R of the bit rate. It is used on the verification side and in debug taps to measure the DAC output numerically, and is synthesizable for on-chip loopback checks.

---
 rtl/jt12_pdm2pcm.sv | 85 ++++++++
 tb/tb_jt12_pdm2pcm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_pdm2pcm.sv
// rtl/jt12_pdm2pcm.sv - second-order CIC decimator turning a 1-bit PDM stream into signed PCM
module jt12_pdm2pcm #(
  parameter int width = 12,
  parameter int log2r = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_en,
  output logic signed [width-1:0] dout,
  output logic                    dout_valid
);

  // Internal word wide enough that the comb output |y| <= 2^(2*log2r) is exact modulo 2^iw.
  localparam int iw    = 2 * log2r + 2;
  // Right shift that maps the CIC gain R^2 onto the output full scale.
  localparam int shift = 2 * log2r - (width - 1);

  localparam logic [log2r-1:0]      cnt_one = log2r'(1);
  localparam logic signed [iw-1:0]  pos_ovf = iw'(1) << (width - 1);
  localparam logic signed [width-1:0] pos_max = {1'b0, {(width-1){1'b1}}};

  logic signed [iw-1:0]    x;
  logic signed [iw-1:0]    i1;
  logic signed [iw-1:0]    i2;
  logic signed [iw-1:0]    d1;
  logic signed [iw-1:0]    d2;
  logic signed [iw-1:0]    c1;
  logic signed [iw-1:0]    y;
  logic signed [iw-1:0]    ys;
  logic signed [width-1:0] dout_next;
  logic [log2r-1:0]        cnt;
  logic                    smp;

  // PDM bit mapped to +1 / -1: all-ones except the LSB when din is 0.
  assign x = {{(iw-1){~din}}, 1'b1};

  // Comb differences use the registered integrator and delay values; wrap-around is intended.
  assign c1 = i2 - d1;
  assign y  = c1 - d2;

  // Scale to the output width; +full-scale is the single value that needs clipping.
  always_comb begin
    ys        = y >>> shift;
    dout_next = ys[width-1:0];
    if (ys == pos_ovf) begin
      dout_next = pos_max;
    end
  end

  // Integrators and decimation counter advance once per accepted PDM bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1  <= '0;
      i2  <= '0;
      cnt <= '0;
      smp <= 1'b0;
    end else begin
      smp <= din_en && (&cnt);
      if (din_en) begin
        i1  <= i1 + x;
        i2  <= i2 + i1;
        cnt <= cnt + cnt_one;
      end
    end
  end

  // Comb stages and output register fire on the edge after a sampling strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1         <= '0;
      d2         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= smp;
      if (smp) begin
        d1   <= i2;
        d2   <= c1;
        dout <= dout_next;
      end
    end
  end

endmodule

// File: tb/tb_jt12_pdm2pcm.sv
// tb/tb_jt12_pdm2pcm.sv - self-checking bench for jt12_pdm2pcm against a triangular-FIR model
module tb_jt12_pdm2pcm;

  localparam int WIDTH = 12;
  localparam int LOG2R = 6;
  localparam int R     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_en = 1'b0;
  logic signed [WIDTH-1:0] dout;
  logic dout_valid;

  int checks = 0;
  int errors = 0;

  jt12_pdm2pcm #(.width(WIDTH), .log2r(LOG2R)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_en(din_en),
    .dout(dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // Reference: a 2nd-order CIC sampled every R bits equals a triangular FIR of length 2R
  // over the bits since reset (bits before reset count as 0), followed by scaling and clipping.
  int hist[$];
  int nstrobe   = 0;
  bit pend      = 1'b0;
  int pend_val  = 0;
  bit exp_valid = 1'b0;
  int exp_dout  = 0;
  bit armed     = 1'b0;

  function automatic int cic_word();
    int acc;
    int j;
    acc = 0;
    for (int i = 0; i < hist.size(); i++) begin
      j = hist.size() - 1 - i;
      acc += ((j < R) ? j : (2 * R - j)) * hist[i];
    end
    acc = acc >>> (2 * LOG2R - (WIDTH - 1));
    if (acc == 2 ** (WIDTH - 1)) acc = 2 ** (WIDTH - 1) - 1;
    return acc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      nstrobe   = 0;
      pend      = 1'b0;
      exp_valid = 1'b0;
      exp_dout  = 0;
      armed     = 1'b1;
    end else begin
      exp_valid = 1'b0;
      if (pend) begin
        exp_valid = 1'b1;
        exp_dout  = pend_val;
        pend      = 1'b0;
      end
      if (din_en) begin
        hist.push_back(din ? 1 : -1);
        if (hist.size() > 2 * R) void'(hist.pop_front());
        nstrobe++;
        if (nstrobe % R == 0) begin
          pend     = 1'b1;
          pend_val = cic_word();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (dout_valid !== exp_valid) begin
        errors++;
        $display("FAIL dout_valid at %0t: got %b expected %b", $time, dout_valid, exp_valid);
      end
      checks++;
      if (int'(dout) != exp_dout || $isunknown(dout)) begin
        errors++;
        $display("FAIL dout at %0t: got %0d expected %0d", $time, dout, exp_dout);
      end
    end
  end

  // Pulse bookkeeping for spacing and averaging checks.
  int cyc = 0;
  int last_vc = 0;
  int prev_vc = 0;
  int nvalid = 0;
  int words[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      prev_vc = last_vc;
      last_vc = cyc;
      nvalid++;
      words.push_back(int'(dout));
    end
  end

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive nstr strobes; bit k takes pat[k % plen]; strobes are gap cycles apart.
  task automatic run(input logic [3:0] pat, input int plen, input int nstr, input int gap);
    for (int k = 0; k < nstr; k++) begin
      @(negedge clk);
      din = pat[k % plen];
      din_en = 1'b1;
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        din_en = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din_en = 1'b0;
    end
  endtask

  task automatic steady(input string name, input logic [3:0] pat, input int plen,
                        input int gap, input int expv, input int espace);
    do_reset();
    run(pat, plen, 5 * R, gap);
    idle(3);
    check_int({name, "_word"}, int'(dout), expv);
    check_int({name, "_spacing"}, last_vc - prev_vc, espace);
  endtask

  initial begin
    int n;
    int acc;
    int sum;
    int v0;
    bit b;

    @(negedge clk);
    @(negedge clk);
    check_int("reset_dout", int'(dout), 0);
    check_int("reset_valid", int'(dout_valid), 0);
    rst = 1'b0;

    steady("all_ones",  4'b0001, 1, 1, 2047, R);
    steady("all_zeros", 4'b0000, 1, 1, -2048, R);
    steady("alternate", 4'b0101, 2, 1, 0, R);
    steady("three_one", 4'b0111, 4, 1, 1024, R);
    steady("gap5_ones", 4'b0001, 1, 5, 2047, 5 * R);

    // First-order sigma-delta source standing in for the DAC loopback at -1023.
    do_reset();
    words.delete();
    acc = 0;
    for (int k = 0; k < 24 * R; k++) begin
      @(negedge clk);
      b = (acc >= 0);
      acc += -1023 - (b ? 2048 : -2048);
      din = b;
      din_en = 1'b1;
    end
    idle(3);
    sum = 0;
    for (int k = 8; k < 24 && k < words.size(); k++) sum += words[k];
    check_int("loopback_count", words.size(), 24);
    check_int("loopback_mean_ok", (sum / 16 >= -1031 && sum / 16 <= -1015) ? 1 : 0, 1);

    // Reset in the middle of a frame, together with a strobe.
    do_reset();
    run(4'b0001, 1, 40, 1);
    @(negedge clk);
    rst = 1'b1;
    din_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("midreset_valid", int'(dout_valid), 0);
    check_int("midreset_dout", int'(dout), 0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (dout_valid === 1'b1) break;
    end
    check_int("midreset_first_valid_cycles", n, R + 1);
    check_int("midreset_transient_word", int'(dout), 1008);

    // Reset on the edge between the sampling strobe and the output load.
    do_reset();
    run(4'b0001, 1, R, 1);
    @(negedge clk);
    rst = 1'b1;
    v0 = nvalid;
    @(negedge clk);
    rst = 1'b0;
    din_en = 1'b0;
    idle(10);
    check_int("smp_reset_no_pulse", nvalid - v0, 0);

    // Random bits, random strobes, occasional resets.
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      din = 1'($urandom_range(0, 1));
      din_en = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 999) < 2);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
